// File: rtl/xgriscv_muldiv.sv
// ============================================================================
// Module   : xgriscv_muldiv
// Purpose  : Iterative RV32M multiply/divide unit with a one-cycle regfile
//            writeback port. Divide-by-zero and signed overflow take a fast path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xgriscv_muldiv #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               kill,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  logic [RFIDX_W-1:0] rd_idx,
    output logic               busy,
    output logic               done,
    output logic               wb_we,
    output logic [RFIDX_W-1:0] wb_wa,
    output logic [XLEN-1:0]    wb_wd
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]         op;
    logic [RFIDX_W-1:0] rd;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               bypass;
    logic [XLEN-1:0]    opnd;
    logic [2*XLEN-1:0]  acc;

    logic               accept;
    logic               signed_a, signed_b, sa, sb;
    logic [XLEN-1:0]    mag_a, mag_b;
    logic               special;
    logic [XLEN-1:0]    special_res;
    logic [2*XLEN-1:0]  acc_step;
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_tmp;
    logic [XLEN:0]      div_diff;
    logic [2*XLEN-1:0]  prod_s;
    logic [XLEN-1:0]    quo_s, rem_s;
    logic [XLEN-1:0]    result;

    assign busy   = (state != S_IDLE);
    assign accept = (state == S_IDLE) && start && !kill;

    // Operand conditioning from the raw request (used only on accept).
    always_comb begin
        signed_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sa          = a[XLEN-1] & signed_a;
        sb          = b[XLEN-1] & signed_b;
        mag_a       = sa ? (~a + 1'b1) : a;
        mag_b       = sb ? (~b + 1'b1) : b;
        special     = 1'b0;
        special_res = '0;
        if (funct3[2]) begin
            if (b == '0) begin
                special     = 1'b1;
                special_res = funct3[1] ? a : '1;
            end else if (!funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
                special     = 1'b1;
                special_res = funct3[1] ? '0 : a;
            end
        end
    end

    // One iteration: shift-add multiply, or one restoring-divide quotient bit.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_tmp  = acc[2*XLEN-1:XLEN-1];
        div_diff = div_tmp - {1'b0, opnd};
        acc_step = acc;
        if (op[2]) begin
            if (div_tmp >= {1'b0, opnd})
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_step = {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_s = neg ? (~acc + 1'b1) : acc;
        quo_s  = neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_s  = neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        result = '0;
        if (bypass) begin
            result = acc[XLEN-1:0];
        end else begin
            case (op)
                3'b000:                 result = prod_s[XLEN-1:0];
                3'b001, 3'b010, 3'b011: result = prod_s[2*XLEN-1:XLEN];
                3'b100, 3'b101:         result = quo_s;
                default:                result = rem_s;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = special ? S_FIN : S_CALC;
            S_CALC: begin
                if (kill)
                    state_nxt = S_IDLE;
                else if (cnt == CNT_LAST)
                    state_nxt = S_FIN;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op     <= '0;
            rd     <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            bypass <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
        end else if (accept) begin
            op     <= funct3;
            rd     <= rd_idx;
            cnt    <= '0;
            bypass <= special;
            if (special) begin
                neg  <= 1'b0;
                opnd <= '0;
                acc  <= {{XLEN{1'b0}}, special_res};
            end else begin
                // REM takes the dividend sign; everything else the sign product.
                neg  <= (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
                opnd <= funct3[2] ? mag_b : mag_a;
                acc  <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
            end
        end else if (state == S_CALC && !kill) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
        end
    end

    // Writeback registers are loaded on the edge leaving FIN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done  <= 1'b0;
            wb_we <= 1'b0;
            wb_wa <= '0;
            wb_wd <= '0;
        end else begin
            done  <= 1'b0;
            wb_we <= 1'b0;
            if (state == S_FIN && !kill) begin
                done  <= 1'b1;
                wb_we <= (rd != '0);
                wb_wa <= rd;
                wb_wd <= result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xgriscv_muldiv.sv
// ============================================================================
// Module   : tb_xgriscv_muldiv
// Purpose  : Directed self-checking bench for xgriscv_muldiv.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xgriscv_muldiv;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_idx;
    logic        busy;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;

    int n_checks = 0;
    int n_fail   = 0;

    xgriscv_muldiv #(.XLEN(32), .RFIDX_W(5)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .rd_idx (rd_idx),
        .busy   (busy),
        .done   (done),
        .wb_we  (wb_we),
        .wb_wa  (wb_wa),
        .wb_wd  (wb_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op at edge E0; n counts edges after E0 until done is seen.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat, input int poke_at);
        int n;
        @(negedge clk);
        start = 1'b1; funct3 = f; a = x; b = y; rd_idx = rd;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1 n++;
            start = (n == poke_at);
            if (start) begin
                funct3 = 3'b000; a = 32'hFFFF_FFFF; b = 32'h1234_5678; rd_idx = 5'd9;
            end
        end
        start = 1'b0;
        check_eq({tag, " latency"}, n, lat);
        check_eq({tag, " wd"}, wb_wd, exp);
        check_eq({tag, " we"}, {31'b0, wb_we}, {31'b0, rd != 5'd0});
        check_eq({tag, " wa"}, {27'b0, wb_wa}, {27'b0, rd});
        @(posedge clk);
        #1 check_eq({tag, " done once"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic saw;
        rstn = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = '0; a = '0; b = '0; rd_idx = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", {31'b0, busy}, 32'd0);
        check_eq("reset done", {31'b0, done}, 32'd0);
        check_eq("reset we", {31'b0, wb_we}, 32'd0);
        check_eq("reset wa", {27'b0, wb_wa}, 32'd0);
        check_eq("reset wd", wb_wd, 32'd0);
        rstn = 1'b1;

        run_op("MUL",       3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33, 0);
        run_op("MULH",      3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 33, 0);
        run_op("MULHU",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33, 0);
        run_op("MULHSU",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 33, 0);
        run_op("DIV",       3'b100, 32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFD, 33, 0);
        run_op("REM",       3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, 33, 0);
        run_op("DIVU poke", 3'b101, 32'd100,       32'd7,         5'd7, 32'd14,        33, 5);
        run_op("REMU",      3'b111, 32'd100,       32'd7,         5'd8, 32'd2,         33, 0);
        run_op("DIVU /0",   3'b101, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1, 0);
        run_op("REM %0",    3'b110, 32'd5,         32'd0,         5'd11, 32'd5,         1, 0);
        run_op("DIV ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 0);
        run_op("REM ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1, 0);
        run_op("MUL rd0",   3'b000, 32'd6,         32'd7,         5'd0, 32'd42,        33, 0);

        // Kill at cnt=10.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd5; rd_idx = 5'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check_eq("kill busy", {31'b0, busy}, 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw = saw | done | wb_we;
        end
        check_eq("kill no done", {31'b0, saw}, 32'd0);

        // Kill together with start in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'b101; a = 32'd5; b = 32'd0; rd_idx = 5'd3;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b0;
        check_eq("kill+start busy", {31'b0, busy}, 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            saw = saw | done | busy;
        end
        check_eq("kill+start idle", {31'b0, saw}, 32'd0);

        // Asynchronous reset mid-calculation at cnt=20.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'd9; rd_idx = 5'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("async rst busy", {31'b0, busy}, 32'd0);
        check_eq("async rst done", {31'b0, done}, 32'd0);
        check_eq("async rst we", {31'b0, wb_we}, 32'd0);
        check_eq("async rst wd", wb_wd, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op("MUL after rst", 3'b000, 32'd3, 32'd4, 5'd15, 32'd12, 33, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
